// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the Light RV32I core.
// Define LIGHT_MC_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module mc_ctrl_fsm #(
    parameter int INST_WIDTH = 32
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [INST_WIDTH-1:0] i_Instr,
    input  logic                  i_MemReady,
    input  logic                  i_BranchTaken,
    output logic [2:0]            o_ExtOp,
    output logic                  o_MemReq,
    output logic                  o_MemWrite,
    output logic                  o_AddrSel,
    output logic                  o_IrWrite,
    output logic                  o_PcWrite,
    output logic [1:0]            o_PcSrc,
    output logic [1:0]            o_AluSrcA,
    output logic [1:0]            o_AluSrcB,
    output logic                  o_RegWrite,
    output logic [1:0]            o_WbSel,
    output logic                  o_Retire,
    output logic                  o_Illegal,
    output logic [2:0]            o_State
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t state, nextState;
    logic [6:0] opcode;
    logic isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore, isOpImm, isOp, isNop, isIllegal;
    logic unusedInstr;

    assign opcode      = i_Instr[6:0];
    assign unusedInstr = ^i_Instr[INST_WIDTH-1:7];
    assign isLui       = opcode == 7'b0110111;
    assign isAuipc     = opcode == 7'b0010111;
    assign isJal       = opcode == 7'b1101111;
    assign isJalr      = opcode == 7'b1100111;
    assign isBranch    = opcode == 7'b1100011;
    assign isLoad      = opcode == 7'b0000011;
    assign isStore     = opcode == 7'b0100011;
    assign isOpImm     = opcode == 7'b0010011;
    assign isOp        = opcode == 7'b0110011;
    assign isNop       = opcode == 7'b0001111 || opcode == 7'b1110011;
    assign isIllegal   = !(isLui || isAuipc || isJal || isJalr || isBranch || isLoad
                           || isStore || isOpImm || isOp || isNop);
    assign o_State     = state;

    always_comb
        o_ExtOp = (isLui || isAuipc) ? 3'b100 :
                  isJal              ? 3'b101 :
                  isBranch           ? 3'b011 :
                  isStore            ? 3'b010 : 3'b000;

    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst) state <= FETCH;
        else       state <= nextState;

    always_comb begin
        nextState  = FETCH;
        o_MemReq   = 1'b0;
        o_MemWrite = 1'b0;
        o_AddrSel  = 1'b0;
        o_IrWrite  = 1'b0;
        o_PcWrite  = 1'b0;
        o_PcSrc    = 2'b00;
        o_AluSrcA  = 2'b00;
        o_AluSrcB  = 2'b00;
        o_RegWrite = 1'b0;
        o_WbSel    = 2'b00;
        o_Retire   = 1'b0;
        o_Illegal  = 1'b0;
        case (state)
            FETCH: begin
                o_MemReq  = 1'b1;
                o_IrWrite = i_MemReady;
                o_PcWrite = i_MemReady;
                nextState = i_MemReady ? DECODE : FETCH;
            end
`ifdef LIGHT_MC_ILLEGAL_TRAP_EN
            DECODE: begin
                o_Retire  = isNop;
                nextState = isNop ? FETCH : isIllegal ? TRAP : EXEC;
            end
            TRAP: begin
                o_Illegal = 1'b1;
                nextState = TRAP;
            end
`else
            DECODE: begin
                o_Retire  = isNop || isIllegal;
                nextState = (isNop || isIllegal) ? FETCH : EXEC;
            end
`endif
            EXEC: begin
                o_AluSrcA = (isAuipc || isJal || isBranch) ? 2'b01 : isLui ? 2'b10 : 2'b00;
                o_AluSrcB = isOp ? 2'b00 : 2'b01;
                o_PcWrite = isJal || isJalr || (isBranch && i_BranchTaken);
                o_PcSrc   = (isJal || isJalr || isBranch) ? 2'b01 : 2'b00;
                o_Retire  = isBranch;
                nextState = isBranch ? FETCH : (isLoad || isStore) ? MEM : WB;
            end
            MEM: begin
                o_MemReq   = 1'b1;
                o_AddrSel  = 1'b1;
                o_MemWrite = isStore;
                o_Retire   = isStore && i_MemReady;
                nextState  = !i_MemReady ? MEM : isStore ? FETCH : WB;
            end
            WB: begin
                o_RegWrite = 1'b1;
                o_Retire   = 1'b1;
                o_WbSel    = isLoad ? 2'b01 : (isJal || isJalr) ? 2'b10 : 2'b00;
            end
            default: nextState = FETCH;
        endcase
        // Reset kills the in-flight instruction immediately, without waiting for an edge.
        if (i_Rst) begin
            o_MemReq   = 1'b0;
            o_MemWrite = 1'b0;
            o_AddrSel  = 1'b0;
            o_IrWrite  = 1'b0;
            o_PcWrite  = 1'b0;
            o_PcSrc    = 2'b00;
            o_AluSrcA  = 2'b00;
            o_AluSrcB  = 2'b00;
            o_RegWrite = 1'b0;
            o_WbSel    = 2'b00;
            o_Retire   = 1'b0;
            o_Illegal  = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench for mc_ctrl_fsm; expected per-cycle outputs are queued with the stimulus.
module tb_mc_ctrl_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        ready = 1'b0;
    logic        taken = 1'b0;
    logic [2:0]  extOp, state;
    logic        memReq, memWrite, addrSel, irWrite, pcWrite, regWrite, retire, illegal;
    logic [1:0]  pcSrc, aluSrcA, aluSrcB, wbSel;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .i_Clk(clk), .i_Rst(rst), .i_Instr(instr), .i_MemReady(ready), .i_BranchTaken(taken),
        .o_ExtOp(extOp), .o_MemReq(memReq), .o_MemWrite(memWrite), .o_AddrSel(addrSel),
        .o_IrWrite(irWrite), .o_PcWrite(pcWrite), .o_PcSrc(pcSrc), .o_AluSrcA(aluSrcA),
        .o_AluSrcB(aluSrcB), .o_RegWrite(regWrite), .o_WbSel(wbSel), .o_Retire(retire),
        .o_Illegal(illegal), .o_State(state)
    );

    typedef struct packed {
        logic [2:0] ext;
        logic [2:0] st;
        logic       memReq, memWrite, addrSel, irWrite, pcWrite;
        logic [1:0] pcSrc, aluA, aluB;
        logic       regWrite;
        logic [1:0] wbSel;
        logic       retire, illegal;
    } outs_t;

    outs_t expQ[$];
    logic  rdyQ[$];
    int    nRun = 0, nFail = 0;
    logic [2:0] expExt = '0;
    string tag = "reset";

    function automatic void pushExp(outs_t e, logic r);
        expQ.push_back(e);
        rdyQ.push_back(r);
    endfunction

    function automatic void zeroCyc();
        outs_t e;
        e = '0;
        e.ext = expExt;
        expQ.push_back(e);
    endfunction

    function automatic void fetchCyc(logic r);
        outs_t e;
        e = '0;
        e.ext = expExt; e.memReq = 1'b1; e.irWrite = r; e.pcWrite = r;
        pushExp(e, r);
    endfunction

    function automatic void decodeCyc(logic ret);
        outs_t e;
        e = '0;
        e.ext = expExt; e.st = 3'd1; e.retire = ret;
        pushExp(e, 1'b0);
    endfunction

    function automatic void execCyc(logic [1:0] a, logic [1:0] b, logic pcw, logic [1:0] src, logic ret);
        outs_t e;
        e = '0;
        e.ext = expExt; e.st = 3'd2; e.aluA = a; e.aluB = b; e.pcWrite = pcw; e.pcSrc = src; e.retire = ret;
        pushExp(e, 1'b0);
    endfunction

    function automatic void memCyc(logic wr, logic r, logic retOnReady);
        outs_t e;
        e = '0;
        e.ext = expExt; e.st = 3'd3; e.memReq = 1'b1; e.addrSel = 1'b1; e.memWrite = wr;
        e.retire = retOnReady && r;
        pushExp(e, r);
    endfunction

    function automatic void wbCyc(logic [1:0] sel);
        outs_t e;
        e = '0;
        e.ext = expExt; e.st = 3'd4; e.regWrite = 1'b1; e.retire = 1'b1; e.wbSel = sel;
        pushExp(e, 1'b0);
    endfunction

    function automatic void trapCyc();
        outs_t e;
        e = '0;
        e.ext = expExt; e.st = 3'd5; e.illegal = 1'b1;
        pushExp(e, 1'b1);
    endfunction

    task automatic checkNow();
        outs_t obs, e;
        obs = {extOp, state, memReq, memWrite, addrSel, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
               regWrite, wbSel, retire, illegal};
        e = expQ.pop_front();
        nRun++;
        assert (obs === e) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic drain();
        while (expQ.size() > 0) begin
            ready = rdyQ.pop_front();
            @(negedge clk);
            checkNow();
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        zeroCyc();
        @(negedge clk);
        checkNow();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        tag = "reset";
        zeroCyc();
        @(negedge clk);
        checkNow();
        @(posedge clk);
        #1 rst = 1'b0;

        tag = "addi"; instr = 32'h00500093; expExt = 3'b000;
        fetchCyc(1); decodeCyc(0); execCyc(2'b00, 2'b01, 0, 2'b00, 0); wbCyc(2'b00);
        drain();

        tag = "lw_wait3"; instr = 32'h0000A103; expExt = 3'b000;
        fetchCyc(1); decodeCyc(0); execCyc(2'b00, 2'b01, 0, 2'b00, 0);
        memCyc(0, 0, 0); memCyc(0, 0, 0); memCyc(0, 0, 0); memCyc(0, 1, 0); wbCyc(2'b01);
        drain();

        tag = "beq_taken"; instr = 32'h00000063; expExt = 3'b011; taken = 1'b1;
        fetchCyc(1); decodeCyc(0); execCyc(2'b01, 2'b01, 1, 2'b01, 1);
        drain();

        tag = "beq_not_taken"; taken = 1'b0;
        fetchCyc(1); decodeCyc(0); execCyc(2'b01, 2'b01, 0, 2'b01, 1);
        drain();

        tag = "jal"; instr = 32'h008000EF; expExt = 3'b101;
        fetchCyc(1); decodeCyc(0); execCyc(2'b01, 2'b01, 1, 2'b01, 0); wbCyc(2'b10);
        drain();

        tag = "jalr"; instr = 32'h000080E7; expExt = 3'b000;
        fetchCyc(1); decodeCyc(0); execCyc(2'b00, 2'b01, 1, 2'b01, 0); wbCyc(2'b10);
        drain();

        tag = "lui"; instr = 32'h123450B7; expExt = 3'b100;
        fetchCyc(1); decodeCyc(0); execCyc(2'b10, 2'b01, 0, 2'b00, 0); wbCyc(2'b00);
        drain();

        tag = "auipc"; instr = 32'h00000097; expExt = 3'b100;
        fetchCyc(1); decodeCyc(0); execCyc(2'b01, 2'b01, 0, 2'b00, 0); wbCyc(2'b00);
        drain();

        tag = "add"; instr = 32'h002081B3; expExt = 3'b000;
        fetchCyc(1); decodeCyc(0); execCyc(2'b00, 2'b00, 0, 2'b00, 0); wbCyc(2'b00);
        drain();

        tag = "sw_fetch_wait"; instr = 32'h00112023; expExt = 3'b010;
        fetchCyc(0); fetchCyc(1); decodeCyc(0); execCyc(2'b00, 2'b01, 0, 2'b00, 0); memCyc(1, 1, 1);
        drain();

        tag = "fence_nop"; instr = 32'h0000000F; expExt = 3'b000;
        fetchCyc(1); decodeCyc(1);
        drain();

        tag = "illegal_7f"; instr = 32'h0000007F; expExt = 3'b000;
`ifdef LIGHT_MC_ILLEGAL_TRAP_EN
        fetchCyc(1); decodeCyc(0);
        for (int i = 0; i < 10; i++) trapCyc();
        drain();
        tag = "trap_reset";
        resetPulse();
`else
        fetchCyc(1); decodeCyc(1);
        drain();
`endif

        tag = "sw_mid_mem"; instr = 32'h00112023; expExt = 3'b010;
        fetchCyc(1); decodeCyc(0); execCyc(2'b00, 2'b01, 0, 2'b00, 0); memCyc(1, 0, 1);
        drain();
        tag = "rst_async_drop";
        ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        zeroCyc();
        checkNow();
        tag = "rst_held";
        zeroCyc();
        @(negedge clk);
        checkNow();
        @(posedge clk);
        #1 rst = 1'b0;
        tag = "post_rst_fetch";
        fetchCyc(0);
        drain();

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end
endmodule
